// File: rtl/usb_rx_buffer_writer.sv
// Receive-side packer: checks the DATA-packet CRC16, strips the two CRC bytes and writes the
// payload little-endian into 32-bit buffer words, then hands a good packet to the clk24 core.
module usb_rx_buffer_writer #(
    parameter int BUFFER_SIZE = 1024,
    parameter int WORD_AW     = 8
) (
    input  logic               clk48,
    input  logic               rst_n,
    input  logic               rx_packet_start,
    input  logic               rx_byte_valid,
    input  logic [7:0]         rx_byte,
    input  logic               rx_packet_end,
    input  logic               rx_packet_error,
    input  logic               rx_data1,
    input  logic               rx_setup,
    input  logic [3:0]         rx_endpoint,
    input  logic               buffer_owned_by_core,
    output logic               buffer_write_enable,
    output logic [WORD_AW-1:0] buffer_write_address,
    output logic [31:0]        buffer_write_value,
    output logic               got_packet,
    output logic [15:0]        packet_control,
    output logic               dropped_packet,
    output logic [2:0]         dbg_state
);
    localparam int         MAX_PAYLOAD = (BUFFER_SIZE < 1023) ? BUFFER_SIZE : 1023;
    localparam logic [9:0] MAX_LEN     = 10'(MAX_PAYLOAD);
    localparam logic [15:0] CRC_RESIDUE = 16'hB001;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RECEIVE    = 3'd1,
        S_FLUSH      = 3'd2,
        S_WRITE_HOLD = 3'd3,
        S_HANDOFF    = 3'd4,
        S_DROP       = 3'd5
    } state_t;

    state_t       r_state, w_state_next;
    logic [3:0]   r_ep;
    logic         r_data1, r_setup;
    logic [15:0]  r_crc;
    logic [9:0]   r_count;
    logic [7:0]   r_hb0, r_hb1;
    logic [1:0]   r_hb_cnt;
    logic [31:0]  r_asm;
    logic         r_eop_seen;
    logic         r_we, r_we_first;
    logic [WORD_AW-1:0] r_waddr;
    logic [31:0]  r_wval;
    logic         r_dropped;

    logic         w_in_rx, w_byte_take, w_push_out, w_overflow, w_commit;
    logic         w_wr_full, w_flush, w_start_accept, w_crc_ok, w_drop;
    logic [9:0]   w_count_nxt;
    logic [1:0]   w_hb_cnt_nxt;
    logic [15:0]  w_crc_nxt;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] x;
        x = c;
        for (int i = 0; i < 8; i++) begin
            if (x[0] ^ b[i]) x = (x >> 1) ^ 16'hA001;
            else             x = x >> 1;
        end
        return x;
    endfunction

    // Two newest bytes are held back as potential CRC; only the byte they push out is payload.
    assign w_in_rx      = (r_state == S_RECEIVE) && !rx_packet_error && !rx_packet_start;
    assign w_byte_take  = w_in_rx && rx_byte_valid;
    assign w_push_out   = w_byte_take && (r_hb_cnt == 2'd2);
    assign w_overflow   = w_push_out && (r_count == MAX_LEN);
    assign w_commit     = w_push_out && !w_overflow;
    assign w_wr_full    = w_commit && (r_count[1:0] == 2'd3);
    assign w_flush      = (r_state == S_FLUSH) && !rx_packet_error;
    assign w_count_nxt  = r_count + {9'd0, w_commit};
    assign w_hb_cnt_nxt = (w_byte_take && (r_hb_cnt != 2'd2)) ? r_hb_cnt + 2'd1 : r_hb_cnt;
    assign w_crc_nxt    = w_byte_take ? crc_byte(r_crc, rx_byte) : r_crc;
    assign w_crc_ok     = (w_hb_cnt_nxt == 2'd2) && (w_crc_nxt == CRC_RESIDUE);
    assign w_start_accept = rx_packet_start &&
                            ((r_state == S_IDLE) || ((r_state == S_RECEIVE) && !rx_packet_error));

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_drop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rx_packet_start) begin
                    w_state_next = buffer_owned_by_core ? S_DROP : S_RECEIVE;
                    w_drop       = buffer_owned_by_core;
                end
            end
            S_RECEIVE: begin
                if (rx_packet_error) begin
                    w_state_next = S_IDLE;
                    w_drop       = 1'b1;
                end else if (rx_packet_start) begin
                    w_state_next = buffer_owned_by_core ? S_DROP : S_RECEIVE;
                    w_drop       = 1'b1;
                end else if (w_overflow) begin
                    w_state_next = S_DROP;
                    w_drop       = 1'b1;
                end else if (rx_packet_end) begin
                    if (w_crc_ok) begin
                        w_state_next = (w_count_nxt[1:0] != 2'd0) ? S_FLUSH : S_WRITE_HOLD;
                    end else begin
                        w_state_next = S_DROP;
                        w_drop       = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                w_state_next = rx_packet_error ? S_IDLE : S_WRITE_HOLD;
                w_drop       = rx_packet_error;
            end
            S_WRITE_HOLD: begin
                if (rx_packet_error) begin
                    w_state_next = S_IDLE;
                    w_drop       = 1'b1;
                end else if (!r_we_first) begin
                    w_state_next = S_HANDOFF;
                end
            end
            S_HANDOFF: begin
                w_drop = rx_packet_start;
                if (buffer_owned_by_core) w_state_next = S_IDLE;
            end
            S_DROP: begin
                if (r_eop_seen || rx_packet_end || rx_packet_error) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            r_ep <= '0; r_data1 <= 1'b0; r_setup <= 1'b0;
            r_crc <= '0; r_count <= '0; r_hb0 <= '0; r_hb1 <= '0; r_hb_cnt <= '0;
            r_asm <= '0; r_eop_seen <= 1'b0;
            r_we <= 1'b0; r_we_first <= 1'b0; r_waddr <= '0; r_wval <= '0;
            r_dropped <= 1'b0;
        end else begin
            r_dropped <= w_drop;
            if (w_start_accept) begin
                r_ep       <= rx_endpoint;
                r_data1    <= rx_data1;
                r_setup    <= rx_setup;
                r_crc      <= 16'hFFFF;
                r_count    <= '0;
                r_hb_cnt   <= '0;
                r_hb0      <= '0;
                r_hb1      <= '0;
                r_asm      <= '0;
                r_eop_seen <= 1'b0;
            end else begin
                r_crc    <= w_crc_nxt;
                r_hb_cnt <= w_hb_cnt_nxt;
                r_count  <= w_count_nxt;
                if (w_byte_take) begin
                    r_hb0 <= rx_byte;
                    r_hb1 <= r_hb0;
                end
                if (w_commit) begin
                    if (r_count[1:0] == 2'd3) r_asm <= '0;
                    else                      r_asm[{r_count[1:0], 3'b000} +: 8] <= r_hb1;
                end
                if ((r_state == S_RECEIVE) && rx_packet_end) r_eop_seen <= 1'b1;
            end
            // Strobe runs two clk48 cycles regardless of state so the clk24 side always sees it.
            if (w_wr_full || w_flush) begin
                r_we       <= 1'b1;
                r_we_first <= 1'b1;
                r_waddr    <= r_count[WORD_AW+1:2];
                r_wval     <= w_wr_full ? {r_hb1, r_asm[23:0]} : r_asm;
            end else if (r_we_first) begin
                r_we_first <= 1'b0;
            end else begin
                r_we <= 1'b0;
            end
        end
    end

    // Handshake: got_packet is a level valid held in HANDOFF; buffer_owned_by_core=1 is the
    // acceptance, after which got_packet falls on the next cycle.
    assign got_packet           = (r_state == S_HANDOFF);
    assign packet_control       = {r_setup, r_data1, r_ep, r_count};
    assign buffer_write_enable  = r_we;
    assign buffer_write_address = r_waddr;
    assign buffer_write_value   = r_wval;
    assign dropped_packet       = r_dropped;
    assign dbg_state            = r_state;
endmodule

// File: tb/tb_usb_rx_buffer_writer.sv
// Self-checking bench for usb_rx_buffer_writer: packets are scored against a packet-level
// model (payload -> expected words, control word, drop count).
module tb_usb_rx_buffer_writer;
  logic        clk48 = 1'b0;
  logic        rst_n;
  logic        rx_packet_start, rx_byte_valid, rx_packet_end, rx_packet_error;
  logic [7:0]  rx_byte;
  logic        rx_data1, rx_setup, buffer_owned_by_core;
  logic [3:0]  rx_endpoint;
  logic        buffer_write_enable, got_packet, dropped_packet;
  logic [7:0]  buffer_write_address;
  logic [31:0] buffer_write_value;
  logic [15:0] packet_control;
  logic [2:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;
  logic [39:0] exp_q[$];
  logic [39:0] obs_q[$];
  logic [7:0]  tx_q[$];
  int          drop_cnt = 0;
  int          run = 0;
  logic [39:0] run_word;
  logic        e_got;
  logic [15:0] e_ctrl;
  int          e_drops;

  usb_rx_buffer_writer #(.BUFFER_SIZE(1024), .WORD_AW(8)) dut (
    .clk48(clk48), .rst_n(rst_n),
    .rx_packet_start(rx_packet_start), .rx_byte_valid(rx_byte_valid), .rx_byte(rx_byte),
    .rx_packet_end(rx_packet_end), .rx_packet_error(rx_packet_error),
    .rx_data1(rx_data1), .rx_setup(rx_setup), .rx_endpoint(rx_endpoint),
    .buffer_owned_by_core(buffer_owned_by_core),
    .buffer_write_enable(buffer_write_enable), .buffer_write_address(buffer_write_address),
    .buffer_write_value(buffer_write_value), .got_packet(got_packet),
    .packet_control(packet_control), .dropped_packet(dropped_packet), .dbg_state(dbg_state)
  );

  // clock / reset
  always #10 clk48 = ~clk48;

  // write and drop monitor (sampled on the inactive edge)
  always @(negedge clk48) begin
    if (dropped_packet) drop_cnt++;
    if (buffer_write_enable) begin
      if (run == 0) begin
        run_word = {buffer_write_address, buffer_write_value};
        obs_q.push_back(run_word);
      end else begin
        vectors++;
        if ({buffer_write_address, buffer_write_value} !== run_word) begin
          miscompares++;
          $display("FAIL strobe_stable got %h want %h", {buffer_write_address, buffer_write_value}, run_word);
        end
      end
      run++;
    end else if (run != 0) begin
      vectors++;
      if (run != 2) begin
        miscompares++;
        $display("FAIL strobe_len got %0d cycles want 2", run);
      end
      run = 0;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk48); #1;
  endtask

  task automatic drive_start(input logic [3:0] ep, input logic d1, input logic su);
    rx_endpoint = ep; rx_data1 = d1; rx_setup = su;
    rx_packet_start = 1'b1; tick(); rx_packet_start = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    repeat ($urandom_range(7, 10)) tick();
    rx_byte = b; rx_byte_valid = 1'b1; tick(); rx_byte_valid = 1'b0;
    rx_byte = 8'($urandom);
  endtask

  task automatic drive_end();
    repeat ($urandom_range(1, 4)) tick();
    rx_packet_end = 1'b1; tick(); rx_packet_end = 1'b0;
  endtask

  task automatic send_packet(input logic [3:0] ep, input logic d1, input logic su);
    drive_start(ep, d1, su);
    foreach (tx_q[i]) drive_byte(tx_q[i]);
    drive_end();
    repeat (12) tick();
  endtask

  task automatic clear_obs();
    obs_q.delete(); exp_q.delete(); drop_cnt = 0;
  endtask

  task automatic release_handoff();
    buffer_owned_by_core = 1'b1; tick(); tick();
    buffer_owned_by_core = 1'b0; tick();
  endtask

  // reference model
  function automatic logic [15:0] model_crc(input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ tx_q[i][b]) c = (c >> 1) ^ 16'hA001;
        else                   c = c >> 1;
      end
    return c;
  endfunction

  task automatic append_crc();
    logic [15:0] c;
    c = ~model_crc(tx_q.size());
    tx_q.push_back(c[7:0]);
    tx_q.push_back(c[15:8]);
  endtask

  task automatic model_packet(input logic owned, input logic crc_ok,
                              input logic [3:0] ep, input logic d1, input logic su);
    int raw_n, plen, nwords;
    logic [31:0] w;
    raw_n = tx_q.size();
    plen = (raw_n >= 2) ? raw_n - 2 : 0;
    e_got = 1'b0; e_ctrl = 16'h0; e_drops = 1;
    exp_q.delete();
    if (owned)                         nwords = 0;
    else if (plen > 1023)              nwords = 1023 / 4;
    else if (raw_n < 2 || !crc_ok)     nwords = plen / 4;
    else begin
      nwords = (plen + 3) / 4;
      e_got = 1'b1; e_drops = 0;
      e_ctrl = {su, d1, ep, 10'(plen)};
    end
    for (int k = 0; k < nwords; k++) begin
      w = 32'h0;
      for (int l = 0; l < 4; l++)
        if (4 * k + l < plen) w[8*l +: 8] = tx_q[4*k+l];
      exp_q.push_back({8'(k), w});
    end
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0;
    rx_packet_start = 0; rx_byte_valid = 0; rx_byte = 0; rx_packet_end = 0; rx_packet_error = 0;
    rx_data1 = 0; rx_setup = 0; rx_endpoint = 0; buffer_owned_by_core = 0;
    repeat (3) tick();
    vectors++;
    if ({buffer_write_enable, buffer_write_address, buffer_write_value, got_packet,
         packet_control, dropped_packet} !== 59'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got we=%b a=%h v=%h g=%b c=%h d=%b want all 0", buffer_write_enable,
               buffer_write_address, buffer_write_value, got_packet, packet_control, dropped_packet);
    end
    vectors++;
    if (dbg_state !== 3'd0) begin miscompares++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    rst_n = 1'b1; tick();
  endtask

  task automatic test_zero_length();
    clear_obs(); tx_q.delete(); append_crc();
    send_packet(4'd0, 1'b0, 1'b0);
    model_packet(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    vectors++;
    if (obs_q.size() != 0) begin miscompares++; $display("FAIL zlp_writes got %0d want 0", obs_q.size()); end
    vectors++;
    if (got_packet !== 1'b1) begin miscompares++; $display("FAIL zlp_got got %b want 1", got_packet); end
    vectors++;
    if (packet_control !== e_ctrl) begin miscompares++; $display("FAIL zlp_ctrl got %h want %h", packet_control, e_ctrl); end
    release_handoff();
  endtask

  task automatic test_good_packet();
    clear_obs(); tx_q.delete();
    for (int i = 1; i <= 5; i++) tx_q.push_back(8'(i));
    append_crc();
    send_packet(4'd2, 1'b1, 1'b0);
    model_packet(1'b0, 1'b1, 4'd2, 1'b1, 1'b0);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL good_writes got %0d want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[k]) begin
      vectors++;
      if (obs_q[k] !== exp_q[k]) begin miscompares++; $display("FAIL good_word%0d got %h want %h", k, obs_q[k], exp_q[k]); end
    end
    vectors++;
    if (packet_control !== e_ctrl) begin miscompares++; $display("FAIL good_ctrl got %h want %h", packet_control, e_ctrl); end
    buffer_owned_by_core = 1'b1;
    @(negedge clk48);
    vectors++;
    if (got_packet !== 1'b1) begin miscompares++; $display("FAIL good_got_hold got %b want 1", got_packet); end
    tick();
    vectors++;
    if (got_packet !== 1'b0) begin miscompares++; $display("FAIL good_got_clear got %b want 0", got_packet); end
    buffer_owned_by_core = 1'b0; tick();
  endtask

  task automatic test_bad_crc();
    clear_obs(); tx_q.delete();
    for (int i = 1; i <= 5; i++) tx_q.push_back(8'(i));
    append_crc();
    tx_q[6] = tx_q[6] ^ 8'h01;
    send_packet(4'd2, 1'b1, 1'b0);
    model_packet(1'b0, 1'b0, 4'd2, 1'b1, 1'b0);
    vectors++;
    if (obs_q.size() != exp_q.size() || (exp_q.size() > 0 && obs_q[0] !== exp_q[0])) begin
      miscompares++; $display("FAIL badcrc_writes got n=%0d want n=%0d", obs_q.size(), exp_q.size());
    end
    vectors++;
    if (got_packet !== 1'b0) begin miscompares++; $display("FAIL badcrc_got got %b want 0", got_packet); end
    vectors++;
    if (drop_cnt != e_drops) begin miscompares++; $display("FAIL badcrc_drops got %0d want %0d", drop_cnt, e_drops); end
  endtask

  task automatic test_core_owned();
    clear_obs(); tx_q.delete();
    for (int i = 0; i < 10; i++) tx_q.push_back(8'($urandom));
    buffer_owned_by_core = 1'b1;
    send_packet(4'd1, 1'b0, 1'b0);
    buffer_owned_by_core = 1'b0;
    model_packet(1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
    vectors++;
    if (obs_q.size() != 0) begin miscompares++; $display("FAIL owned_writes got %0d want 0", obs_q.size()); end
    vectors++;
    if (drop_cnt != e_drops) begin miscompares++; $display("FAIL owned_drops got %0d want %0d", drop_cnt, e_drops); end
    vectors++;
    if (dbg_state !== 3'd0) begin miscompares++; $display("FAIL owned_state got %0d want 0", dbg_state); end
  endtask

  task automatic test_overflow();
    clear_obs(); tx_q.delete();
    for (int i = 0; i < 1024; i++) tx_q.push_back(8'($urandom));
    append_crc();
    send_packet(4'd5, 1'b0, 1'b0);
    model_packet(1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL ovf_writes got %0d want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[k]) begin
      vectors++;
      if (obs_q[k] !== exp_q[k]) begin miscompares++; $display("FAIL ovf_word%0d got %h want %h", k, obs_q[k], exp_q[k]); end
    end
    vectors++;
    if (got_packet !== 1'b0) begin miscompares++; $display("FAIL ovf_got got %b want 0", got_packet); end
    vectors++;
    if (drop_cnt != e_drops) begin miscompares++; $display("FAIL ovf_drops got %0d want %0d", drop_cnt, e_drops); end
  endtask

  task automatic test_reset_mid_packet();
    drive_start(4'd9, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive_byte(8'($urandom));
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    clear_obs(); tx_q.delete();
    for (int i = 0; i < 4; i++) tx_q.push_back(8'($urandom));
    append_crc();
    send_packet(4'd3, 1'b0, 1'b0);
    model_packet(1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
    vectors++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      miscompares++; $display("FAIL rstmid_writes got n=%0d want %h", obs_q.size(), exp_q[0]);
    end
    vectors++;
    if (packet_control !== e_ctrl || got_packet !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_ctrl got g=%b c=%h want g=1 c=%h", got_packet, packet_control, e_ctrl);
    end
    vectors++;
    if (drop_cnt != 0) begin miscompares++; $display("FAIL rstmid_drops got %0d want 0", drop_cnt); end
    release_handoff();
  endtask

  task automatic test_restart();
    clear_obs();
    drive_start(4'd7, 1'b0, 1'b0);
    drive_byte(8'hAA); drive_byte(8'hBB);
    repeat (8) tick();
    tx_q.delete();
    for (int i = 0; i < 5; i++) tx_q.push_back(8'($urandom));
    append_crc();
    send_packet(4'd3, 1'b1, 1'b1);
    model_packet(1'b0, 1'b1, 4'd3, 1'b1, 1'b1);
    vectors++;
    if (packet_control !== e_ctrl || got_packet !== 1'b1) begin
      miscompares++; $display("FAIL restart_ctrl got g=%b c=%h want g=1 c=%h", got_packet, packet_control, e_ctrl);
    end
    vectors++;
    if (obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
      miscompares++; $display("FAIL restart_writes got n=%0d want n=2", obs_q.size());
    end
    vectors++;
    if (drop_cnt != 1) begin miscompares++; $display("FAIL restart_drops got %0d want 1", drop_cnt); end
    release_handoff();
  endtask

  task automatic test_error();
    clear_obs();
    drive_start(4'd4, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive_byte(8'(8'h10 + i));
    repeat (2) tick();
    rx_packet_error = 1'b1; tick(); rx_packet_error = 1'b0;
    repeat (12) tick();
    vectors++;
    if (obs_q.size() != 1 || obs_q[0] !== {8'd0, 32'h13121110}) begin
      miscompares++; $display("FAIL error_writes got n=%0d want 1 word 13121110", obs_q.size());
    end
    vectors++;
    if (got_packet !== 1'b0 || drop_cnt != 1) begin
      miscompares++; $display("FAIL error_drop got g=%b d=%0d want g=0 d=1", got_packet, drop_cnt);
    end
    vectors++;
    if (dbg_state !== 3'd0) begin miscompares++; $display("FAIL error_state got %0d want 0", dbg_state); end
  endtask

  task automatic test_random();
    logic [3:0] ep;
    logic d1, su, owned, crc_ok;
    int n, idx;
    for (int p = 0; p < 12; p++) begin
      clear_obs(); tx_q.delete();
      ep = 4'($urandom); d1 = 1'($urandom); su = 1'($urandom);
      owned = ($urandom_range(0, 7) == 0);
      crc_ok = 1'b1;
      if ($urandom_range(0, 9) == 0) begin
        n = $urandom_range(0, 1);
        for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
      end else begin
        n = $urandom_range(0, 13);
        for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
        append_crc();
        if ($urandom_range(0, 3) == 0) begin
          idx = $urandom_range(0, tx_q.size() - 1);
          tx_q[idx] = tx_q[idx] ^ (8'd1 << $urandom_range(0, 7));
          crc_ok = 1'b0;
        end
      end
      buffer_owned_by_core = owned;
      send_packet(ep, d1, su);
      buffer_owned_by_core = 1'b0;
      model_packet(owned, crc_ok, ep, d1, su);
      vectors++;
      if (obs_q.size() != exp_q.size()) begin
        miscompares++; $display("FAIL rand%0d_writes got %0d want %0d", p, obs_q.size(), exp_q.size());
      end else foreach (exp_q[k]) begin
        vectors++;
        if (obs_q[k] !== exp_q[k]) begin miscompares++; $display("FAIL rand%0d_word%0d got %h want %h", p, k, obs_q[k], exp_q[k]); end
      end
      vectors++;
      if (got_packet !== e_got) begin miscompares++; $display("FAIL rand%0d_got got %b want %b", p, got_packet, e_got); end
      if (e_got) begin
        vectors++;
        if (packet_control !== e_ctrl) begin miscompares++; $display("FAIL rand%0d_ctrl got %h want %h", p, packet_control, e_ctrl); end
      end
      vectors++;
      if (drop_cnt != e_drops) begin miscompares++; $display("FAIL rand%0d_drops got %0d want %0d", p, drop_cnt, e_drops); end
      if (got_packet) release_handoff();
    end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_zero_length();
    test_good_packet();
    test_bad_crc();
    test_core_owned();
    test_overflow();
    test_reset_mid_packet();
    test_restart();
    test_error();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
